// File: rtl/whack_game_ctrl.sv
// -----------------------------------------------------------------------------
// whack_game_ctrl
//
// Game-level sequencer for the whack-a-mole datapath. Steps through
// IDLE -> COUNTDOWN -> PLAY -> OVER. It gates the mole LED controller with
// `enable` and times each mole's visible window, which shrinks as the level
// rises. Score, level and miss counts are kept for the display logic.
//
// Optional build macro: GAME_PAUSE_EN adds a `pause_pulse` input and a PAUSE
// state. In that build `state` is 3 bits wide and OVER is encoded as 4.
//
// Ports:
//   clk_game      in   game clock, all state updates on its rising edge
//   rst           in   synchronous, active-high reset
//   start_pulse   in   start button pulse, accepted in IDLE and OVER
//   start_timer   in   new mole shown, (re)starts the mole window
//   hit_pulse     in   current mole was hit
//   pause_pulse   in   (GAME_PAUSE_EN only) toggles PLAY <-> PAUSE
//   enable        out  mole controller enable, high exactly in PLAY
//   timeout_pulse out  one-cycle pulse, the mole window expired
//   score         out  hit count, saturating at 1023
//   level         out  current level, saturating at LEVEL_MAX
//   misses        out  miss count, never above MAX_MISSES
//   level_up      out  one-cycle pulse when level increments
//   game_over     out  high while in OVER
//   state         out  IDLE=0 COUNTDOWN=1 PLAY=2 OVER=3 (PAUSE=3/OVER=4)
// -----------------------------------------------------------------------------
module whack_game_ctrl #(
    parameter int CNT_W           = 24,
    parameter int COUNTDOWN_TICKS = 3000,
    parameter int TICKS_BASE      = 1500,
    parameter int TICKS_STEP      = 150,
    parameter int TICKS_MIN       = 300,
    parameter int HITS_PER_LEVEL  = 5,
    parameter int LEVEL_MAX       = 7,
    parameter int MAX_MISSES      = 3
) (
    input  logic       clk_game,
    input  logic       rst,
    input  logic       start_pulse,
    input  logic       start_timer,
    input  logic       hit_pulse,
`ifdef GAME_PAUSE_EN
    input  logic       pause_pulse,
`endif
    output logic       enable,
    output logic       timeout_pulse,
    output logic [9:0] score,
    output logic [2:0] level,
    output logic [1:0] misses,
    output logic       level_up,
    output logic       game_over,
`ifdef GAME_PAUSE_EN
    output logic [2:0] state
`else
    output logic [1:0] state
`endif
);

`ifdef GAME_PAUSE_EN
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_OVER      = 3'd4
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_PLAY      = 2'd2,
        S_OVER      = 2'd3
    } state_e;
`endif

    localparam int WW   = CNT_W + 4;
    localparam int HL_W = $clog2(HITS_PER_LEVEL + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cd_cnt_q, cd_cnt_d;
    logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
    logic              armed_q, armed_d;
    logic              miss_pend_q, miss_pend_d;
    logic [HL_W-1:0]   hit_lvl_q, hit_lvl_d;
    logic [9:0]        score_q, score_d;
    logic [2:0]        level_q, level_d;
    logic [1:0]        misses_q, misses_d;
    logic              enable_q, enable_d;
    logic              timeout_q, timeout_d;
    logic              level_up_q, level_up_d;
    logic              game_over_q, game_over_d;
    logic              do_hit, do_miss;

    // Window length for the current level. The product is formed wide enough
    // that a large level*step never wraps; anything below the floor, including
    // a subtraction that would go negative, clamps to TICKS_MIN.
    logic [WW-1:0]     win_prod, win_raw, win_len;
    logic [CNT_W-1:0]  win_load;

    assign win_prod = WW'(level_q) * WW'(TICKS_STEP);
    assign win_raw  = WW'(TICKS_BASE) - win_prod;
    assign win_len  = (win_prod > WW'(TICKS_BASE) || win_raw < WW'(TICKS_MIN))
                      ? WW'(TICKS_MIN) : win_raw;
    assign win_load = CNT_W'(win_len - WW'(1));

    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        state_d     = state_q;
        cd_cnt_d    = cd_cnt_q;
        win_cnt_d   = win_cnt_q;
        armed_d     = armed_q;
        miss_pend_d = 1'b0;
        hit_lvl_d   = hit_lvl_q;
        score_d     = score_q;
        level_d     = level_q;
        misses_d    = misses_q;
        timeout_d   = 1'b0;
        level_up_d  = 1'b0;
        do_hit      = 1'b0;
        do_miss     = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_pulse) begin
                    score_d   = '0;
                    level_d   = '0;
                    misses_d  = '0;
                    hit_lvl_d = '0;
                    armed_d   = 1'b0;
                    cd_cnt_d  = CNT_W'(COUNTDOWN_TICKS - 1);
                    state_d   = S_COUNTDOWN;
                end
            end
            S_COUNTDOWN: begin
                if (cd_cnt_q == '0) state_d = S_PLAY;
                else                cd_cnt_d = cd_cnt_q - CNT_W'(1);
            end
            S_PLAY: begin
`ifdef GAME_PAUSE_EN
                if (pause_pulse) begin
                    // Dropping the window and any pending miss: the mole
                    // controller re-arms through start_timer on resume.
                    armed_d = 1'b0;
                    state_d = S_PAUSE;
                end else
`endif
                if (hit_pulse) begin
                    // A hit also settles a pending miss from the previous
                    // cycle's timeout, since the button outranks the timeout.
                    do_hit  = 1'b1;
                    armed_d = 1'b0;
                end else begin
                    if (miss_pend_q) do_miss = 1'b1;
                    if (start_timer) begin
                        win_cnt_d = win_load;
                        armed_d   = 1'b1;
                    end else if (armed_q) begin
                        if (win_cnt_q == '0) begin
                            timeout_d   = 1'b1;
                            armed_d     = 1'b0;
                            miss_pend_d = 1'b1;
                        end else begin
                            win_cnt_d = win_cnt_q - CNT_W'(1);
                        end
                    end
                end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                if (pause_pulse) state_d = S_PLAY;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // A pending miss is resolved even if the state has already moved on.
        if (miss_pend_q && state_q != S_PLAY) begin
            if (hit_pulse) do_hit  = 1'b1;
            else           do_miss = 1'b1;
        end

        if (do_hit) begin
            if (score_q != 10'h3FF) score_d = score_q + 10'd1;
            if (hit_lvl_q == HL_W'(HITS_PER_LEVEL - 1)) begin
                hit_lvl_d = '0;
                if (level_q != 3'(LEVEL_MAX)) begin
                    level_d    = level_q + 3'd1;
                    level_up_d = 1'b1;
                end
            end else begin
                hit_lvl_d = hit_lvl_q + HL_W'(1);
            end
        end

        if (do_miss) begin
            if (int'(misses_q) + 1 >= MAX_MISSES) begin
                misses_d = 2'(MAX_MISSES);
                armed_d  = 1'b0;
                state_d  = S_OVER;
            end else begin
                misses_d = misses_q + 2'd1;
            end
        end

        // Outputs are registered from the next state so they line up with it.
        enable_d    = (state_d == S_PLAY);
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk_game) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            cd_cnt_q    <= '0;
            win_cnt_q   <= '0;
            armed_q     <= 1'b0;
            miss_pend_q <= 1'b0;
            hit_lvl_q   <= '0;
            score_q     <= '0;
            level_q     <= '0;
            misses_q    <= '0;
            enable_q    <= 1'b0;
            timeout_q   <= 1'b0;
            level_up_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cd_cnt_q    <= cd_cnt_d;
            win_cnt_q   <= win_cnt_d;
            armed_q     <= armed_d;
            miss_pend_q <= miss_pend_d;
            hit_lvl_q   <= hit_lvl_d;
            score_q     <= score_d;
            level_q     <= level_d;
            misses_q    <= misses_d;
            enable_q    <= enable_d;
            timeout_q   <= timeout_d;
            level_up_q  <= level_up_d;
            game_over_q <= game_over_d;
        end
    end

    assign enable        = enable_q;
    assign timeout_pulse = timeout_q;
    assign score         = score_q;
    assign level         = level_q;
    assign misses        = misses_q;
    assign level_up      = level_up_q;
    assign game_over     = game_over_q;
    assign state         = state_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_whack_game_ctrl
//
// Two instances: dut_a with default parameters and dut_b with TICKS_STEP=250
// so the window floor is reached. A timeline model (absolute deadlines
// rather than counters) predicts every output each cycle; directed phases
// add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_whack_game_ctrl;

    localparam int CD_TICKS = 3000;
    localparam int BASE     = 1500;
    localparam int STEP_A   = 150;
    localparam int STEP_B   = 250;
    localparam int TMIN     = 300;
    localparam int HPL      = 5;
    localparam int LMAX     = 7;
    localparam int MMAX     = 3;

    localparam logic [2:0] SP  = 3'b100;
    localparam logic [2:0] ST  = 3'b010;
    localparam logic [2:0] HIT = 3'b001;

    logic clk_game = 1'b0;
    always #5 clk_game = ~clk_game;

    logic rst = 1'b1;
    logic sp_a = 1'b0, st_a = 1'b0, hit_a = 1'b0;
    logic sp_b = 1'b0, st_b = 1'b0, hit_b = 1'b0;

    logic       en_a, tp_a, lu_a, go_a, en_b, tp_b, lu_b, go_b;
    logic [9:0] score_a, score_b;
    logic [2:0] level_a, level_b;
    logic [1:0] misses_a, misses_b, state_a, state_b;

    whack_game_ctrl dut_a (
        .clk_game(clk_game), .rst(rst), .start_pulse(sp_a), .start_timer(st_a),
        .hit_pulse(hit_a), .enable(en_a), .timeout_pulse(tp_a), .score(score_a),
        .level(level_a), .misses(misses_a), .level_up(lu_a), .game_over(go_a),
        .state(state_a)
    );

    whack_game_ctrl #(.TICKS_STEP(STEP_B)) dut_b (
        .clk_game(clk_game), .rst(rst), .start_pulse(sp_b), .start_timer(st_b),
        .hit_pulse(hit_b), .enable(en_b), .timeout_pulse(tp_b), .score(score_b),
        .level(level_b), .misses(misses_b), .level_up(lu_b), .game_over(go_b),
        .state(state_b)
    );

    wire [20:0] out_a = {state_a, en_a, tp_a, score_a, level_a, misses_a, lu_a, go_a};
    wire [20:0] out_b = {state_b, en_b, tp_b, score_b, level_b, misses_b, lu_b, go_b};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int     st;        // 0 idle, 1 countdown, 2 play, 3 over
        longint play_at;   // edge index at which countdown ends
        bit     armed;
        longint deadline;  // edge index at which the window expires
        bit     pend;      // a timeout was just reported, miss undecided
        int     score, level, misses, hits;
        bit     tp, lu;
    } model_t;

    function automatic int win_len(input int lvl, input int step);
        int w;
        w = BASE - lvl * step;
        return (w < TMIN) ? TMIN : w;
    endfunction

    function automatic model_t reset_model();
        model_t m;
        m.st = 0; m.play_at = 0; m.armed = 0; m.deadline = 0; m.pend = 0;
        m.score = 0; m.level = 0; m.misses = 0; m.hits = 0; m.tp = 0; m.lu = 0;
        return m;
    endfunction

    function automatic model_t mstep(input model_t m, input longint n, input bit r,
                                     input bit sp, input bit st, input bit hit,
                                     input int step);
        model_t nx;
        bit got_hit, got_miss;
        if (r) return reset_model();
        nx = m; nx.tp = 0; nx.lu = 0; nx.pend = 0;
        got_hit = 0; got_miss = 0;
        case (m.st)
            0, 3: if (sp) begin
                nx.score = 0; nx.level = 0; nx.misses = 0; nx.hits = 0;
                nx.armed = 0; nx.st = 1; nx.play_at = n + CD_TICKS;
            end
            1: if (n == m.play_at) nx.st = 2;
            default: begin
                if (hit) begin
                    got_hit = 1; nx.armed = 0;
                end else begin
                    if (m.pend) got_miss = 1;
                    if (st) begin
                        nx.armed = 1; nx.deadline = n + win_len(m.level, step);
                    end else if (m.armed && n == m.deadline) begin
                        nx.tp = 1; nx.armed = 0; nx.pend = 1;
                    end
                end
            end
        endcase
        if (m.pend && m.st != 2) begin
            if (hit) got_hit = 1; else got_miss = 1;
        end
        if (got_hit) begin
            nx.score = (m.score < 1023) ? m.score + 1 : 1023;
            nx.hits = m.hits + 1;
            if (nx.hits == HPL) begin
                nx.hits = 0;
                if (m.level < LMAX) begin nx.level = m.level + 1; nx.lu = 1; end
            end
        end
        if (got_miss) begin
            nx.misses = m.misses + 1;
            if (nx.misses >= MMAX) begin nx.misses = MMAX; nx.st = 3; nx.armed = 0; end
        end
        return nx;
    endfunction

    function automatic logic [20:0] pack_model(input model_t m);
        return {2'(m.st), (m.st == 2), m.tp, 10'(m.score), 3'(m.level),
                2'(m.misses), m.lu, (m.st == 3)};
    endfunction

    model_t m_a, m_b;
    longint n_edge = 0;
    bit     cmp_en = 0;
    int     tp_cnt_a = 0, lu_cnt_a = 0;

    always @(posedge clk_game) begin
        m_a    <= mstep(m_a, n_edge, rst, sp_a, st_a, hit_a, STEP_A);
        m_b    <= mstep(m_b, n_edge, rst, sp_b, st_b, hit_b, STEP_B);
        n_edge <= n_edge + 1;
    end

    // Event counters sampled just after the edge, read by the directed phases.
    always @(posedge clk_game) begin
        #1;
        if (tp_a === 1'b1) tp_cnt_a++;
        if (lu_a === 1'b1) lu_cnt_a++;
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk_game) begin
        if (cmp_en) begin
            check("model_a", out_a, pack_model(m_a));
            check("model_b", out_b, pack_model(m_b));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int k);
        repeat (k) @(negedge clk_game);
    endtask

    task automatic drive(input int d, input logic [2:0] v);
        if (d == 0) {sp_a, st_a, hit_a} = v; else {sp_b, st_b, hit_b} = v;
        @(negedge clk_game);
        if (d == 0) {sp_a, st_a, hit_a} = 3'b0; else {sp_b, st_b, hit_b} = 3'b0;
    endtask

    function automatic logic tp_of(input int d);
        return (d == 0) ? tp_a : tp_b;
    endfunction

    function automatic logic [1:0] state_of(input int d);
        return (d == 0) ? state_a : state_b;
    endfunction

    task automatic pair(input int d);
        drive(d, ST);
        idle(3);
        drive(d, HIT);
        idle(1);
    endtask

    // Edges from start_timer being sampled to timeout_pulse being visible.
    task automatic measure_window(input int d, output int k);
        drive(d, ST);
        k = 0;
        while (tp_of(d) !== 1'b1 && k < 4000) begin
            @(negedge clk_game);
            k++;
        end
    endtask

    task automatic wait_state(input int d, input logic [1:0] s, input int limit);
        int k;
        k = 0;
        while (state_of(d) !== s && k < limit) begin
            @(negedge clk_game);
            k++;
        end
        check("wait_state", state_of(d), s);
    endtask

    task automatic ensure_play_a();
        if (state_a != 2'd2) begin
            if (state_a == 2'd3 || state_a == 2'd0) drive(0, SP);
            wait_state(0, 2'd2, 5000);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, gap, j;

        m_a = reset_model();
        m_b = reset_model();
        rst = 1'b1;
        repeat (3) @(negedge clk_game);
        cmp_en = 1;
        check("reset_a", out_a, 21'd0);
        check("reset_b", out_b, 21'd0);
        rst = 1'b0;
        idle(2);

        // Countdown length.
        drive(0, SP);
        k = 0;
        while (state_a == 2'd1 && k < 5000) begin
            k++;
            @(negedge clk_game);
        end
        check("countdown_len", k, 3000);
        check("play_state", state_a, 2'd2);
        check("play_enable", en_a, 1'b1);

        // Level-0 window and the resulting miss.
        measure_window(0, k);
        check("win_lvl0", k, 1500);
        idle(1);
        check("misses_first", misses_a, 2'd1);

        // Five hits advance one level.
        repeat (5) pair(0);
        check("score_5", score_a, 10'd5);
        check("level_1", level_a, 3'd1);
        check("level_up_once", lu_cnt_a, 1);

        measure_window(0, k);
        check("win_lvl1", k, 1350);
        idle(1);
        check("misses_second", misses_a, 2'd2);

        // Hit reported while the timeout is still visible: hit wins.
        drive(0, ST);
        k = 0;
        while (tp_a !== 1'b1 && k < 4000) begin
            @(negedge clk_game);
            k++;
        end
        hit_a = 1'b1;
        @(negedge clk_game);
        hit_a = 1'b0;
        check("race_score", score_a, 10'd6);
        check("race_misses", misses_a, 2'd2);

        repeat (29) pair(0);
        check("level_7", level_a, 3'd7);
        check("score_35", score_a, 10'd35);
        check("level_up_seven", lu_cnt_a, 7);
        repeat (5) pair(0);
        check("level_sat", level_a, 3'd7);
        check("no_level_up_at_max", lu_cnt_a, 7);

        measure_window(0, k);
        check("win_lvl7", k, 450);
        idle(1);
        check("over_state", state_a, 2'd3);
        check("over_flag", go_a, 1'b1);
        check("over_enable", en_a, 1'b0);

        drive(0, HIT);
        drive(0, ST);
        idle(2);
        check("over_score_held", score_a, 10'd40);

        drive(0, SP);
        check("restart_state", state_a, 2'd1);
        check("restart_score", score_a, 10'd0);
        check("restart_level", level_a, 3'd0);
        check("restart_misses", misses_a, 2'd0);
        wait_state(0, 2'd2, 5000);

        // Randomised mole episodes; the model compare does the checking.
        for (int e = 0; e < 10; e++) begin
            ensure_play_a();
            if ($urandom_range(0, 3) == 0) drive(0, SP);
            drive(0, ST);
            if ($urandom_range(0, 3) == 0) begin
                idle($urandom_range(1, 200));
                drive(0, ST);
            end
            gap = $urandom_range(1, 1700);
            j = 0;
            while (j < gap && tp_a !== 1'b1) begin
                @(negedge clk_game);
                j++;
            end
            if (tp_a === 1'b1) begin
                if ($urandom_range(0, 1) == 1) drive(0, HIT); else idle(1);
            end else begin
                drive(0, HIT);
            end
            idle($urandom_range(0, 5));
        end

        // Reset while a window is running.
        ensure_play_a();
        drive(0, ST);
        idle(20);
        rst = 1'b1;
        @(negedge clk_game);
        check("reset_mid_play", out_a, 21'd0);
        rst = 1'b0;
        tp_cnt_a = 0;
        idle(2000);
        check("no_timeout_after_reset", tp_cnt_a, 0);

        // Window floor with the larger step.
        drive(1, SP);
        wait_state(1, 2'd2, 5000);
        repeat (35) pair(1);
        check("b_level_7", level_b, 3'd7);
        check("b_score_35", score_b, 10'd35);
        measure_window(1, k);
        check("b_win_clamped", k, 300);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/whack_game_ctrl.md
Name: whack_game_ctrl

Overview:
Game-level sequencer for the whack-a-mole datapath. It steps through IDLE, COUNTDOWN, PLAY and OVER, and drives `enable` and `timeout_pulse` into the mole LED controller. It times each mole's visible window from `start_timer`, which shortens as the level rises, and keeps score, level and miss counts for the display logic.

Parameters:
CNT_W, 24, width of the countdown and mole-window counters
COUNTDOWN_TICKS, 3000, clk_game cycles spent in COUNTDOWN before play starts
TICKS_BASE, 1500, mole window length in cycles at level 0
TICKS_STEP, 150, window reduction per level
TICKS_MIN, 300, floor on the window length
HITS_PER_LEVEL, 5, hits needed to advance one level
LEVEL_MAX, 7, saturation value for `level`
MAX_MISSES, 3, misses that end the game

Ports:
clk_game  in  1  game clock
rst  in  1  synchronous, active-high reset
start_pulse  in  1  one-cycle pulse from the debounced start button
start_timer  in  1  one-cycle pulse from the mole controller: a new mole is shown
hit_pulse  in  1  one-cycle pulse from the mole controller: the current mole was hit
enable  out  1  mole controller enable
timeout_pulse  out  1  one-cycle pulse: the current mole's window has expired
score  out  10  hit count, saturates at 1023
level  out  3  current level
misses  out  2  miss count
level_up  out  1  one-cycle pulse when `level` increments
game_over  out  1  high while in OVER
state  out  2  IDLE=0, COUNTDOWN=1, PLAY=2, OVER=3 (PAUSE=3 with the optional feature, see below)

Behaviour:
- All registers update on the rising edge of clk_game.
- Reset: state=IDLE, and every output plus all internal counters and flags are 0.
- Outputs are registered; `enable` is 1 exactly when state=PLAY.
- Internal state:
  - `win_cnt` (CNT_W bits) counts down the mole window.
  - `armed` flags that a window is running.
  - `miss_pend` holds a one-cycle pending miss.
  - `hit_lvl` counts hits within the current level.
- IDLE: on `start_pulse`, clear score, level, misses and `hit_lvl`, load the countdown counter with COUNTDOWN_TICKS-1, and go to COUNTDOWN.
- COUNTDOWN: decrement each cycle; when the counter is 0, go to PLAY. The total time in COUNTDOWN is exactly COUNTDOWN_TICKS cycles. `start_pulse` is ignored here.
- Window length: `win = max(TICKS_BASE - level*TICKS_STEP, TICKS_MIN)`. Compute it at CNT_W+4 bits; any underflow clamps to TICKS_MIN.
- PLAY, window start: `start_timer` loads `win_cnt` with win-1 and sets `armed`. A `start_timer` arriving while already armed reloads the counter.
- PLAY, window running: while armed, `win_cnt` decrements each cycle.
- PLAY, expiry: when armed and `win_cnt`=0 and `hit_pulse`=0, assert `timeout_pulse` next cycle, clear `armed` and set `miss_pend`.
- PLAY, hit: if `hit_pulse`=1, clear `armed` and `miss_pend`, then:
  - `score` increments, saturating at 1023;
  - `hit_lvl` increments;
  - when `hit_lvl` reaches HITS_PER_LEVEL it clears, `level` increments (saturating at LEVEL_MAX) and `level_up` pulses. At LEVEL_MAX there is no `level_up` pulse.
- Hit versus timeout race: the mole controller gives a button priority over `timeout_pulse`, so a hit may be reported one cycle after the timeout.
  - In the cycle after `timeout_pulse`, `miss_pend` resolves.
  - If `hit_pulse`=1 that cycle, count a hit and no miss.
  - Otherwise `misses` increments.
- Game end: if a miss brings `misses` to MAX_MISSES, go to OVER on the same edge. `misses` never exceeds MAX_MISSES.
- OVER: `enable`=0 and `game_over`=1; score and level are held. `start_pulse` behaves as in IDLE, moving to COUNTDOWN and clearing the counters.
- Inputs outside PLAY: `start_timer` and `hit_pulse` are ignored and do not touch any counter. The one exception is the `miss_pend` resolution cycle, which is still evaluated.
- Reset mid-game: a synchronous reset returns to the full reset state on the next edge, whatever the current state.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- When defined:
  - Add input `pause_pulse` (1 bit) and state PAUSE; in this build `state` is 3 bits and OVER=4.
  - In PLAY, `pause_pulse` enters PAUSE. This clears `armed` and `miss_pend` without counting a miss, and `enable`=0.
  - In PAUSE, `pause_pulse` returns to PLAY; the mole controller then re-arms the window through `start_timer`.
  - Score, level and misses are held while paused.
- When undefined: there is no PAUSE port or state, and `state` is 2 bits as listed under Ports.

Test Plan:
1. Reset, then `start_pulse` → `state`=1 for exactly COUNTDOWN_TICKS cycles, then `state`=2 and `enable`=1.
2. In PLAY at level 0, `start_timer` with no hit → `timeout_pulse` exactly 1500 cycles after `start_timer`; `misses`=1 one cycle later.
3. Five `start_timer`→`hit_pulse` pairs → `score`=5, `level`=1, one `level_up` pulse; the next window is 1350 cycles. At level 7 the window is 450; with TICKS_STEP=250 it is clamped to 300.
4. `hit_pulse` in the cycle immediately after `timeout_pulse` → `score` increments and `misses` is unchanged.
5. Three unhit windows → `state`=3 and `game_over`=1; further `hit_pulse` leaves `score` unchanged; `start_pulse` → COUNTDOWN with score, level and misses all 0.
6. `rst` asserted mid-PLAY with `armed`=1 → next cycle all outputs 0, `state`=IDLE, and no `timeout_pulse` afterwards.
